// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial_adder block.
package serial_adder_pkg;

    // Sequencer states for the digit-serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width: clog2(WIDTH/DIGIT), never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the ripple chain of the serial adder is built from these.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock through a
// chain of fa_cell instances with a registered carry between digits.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the two's-complement
// overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Reject configurations the digit slicing cannot support.
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] psum_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [DIGIT:0]   chain_c_s;
    logic [DIGIT-1:0] dsum_s;
    logic [WIDTH-1:0] psum_next_s;

    // The registered carry feeds the bottom of this digit's ripple chain.
    assign chain_c_s[0] = carry_r;

    for (genvar i = 0; i < DIGIT; i++) begin : g_chain
        fa_cell u_fa (
            .a    (a_sh_r[i]),
            .b    (b_sh_r[i]),
            .cin  (chain_c_s[i]),
            .s    (dsum_s[i]),
            .cout (chain_c_s[i+1])
        );
    end

    // New digit enters the partial sum from the MSB end; after N digits the
    // first digit has reached bit 0.
    assign psum_next_s = WIDTH'({dsum_s, psum_r} >> DIGIT);

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_cin_s;
    logic ovf_s;

    // On the final digit, bit DIGIT-1 of the chain is the operand MSB.
    assign msb_cin_s = chain_c_s[DIGIT-1];
    assign ovf_s     = msb_cin_s ^ chain_c_s[DIGIT];
`endif

    // Sequencer, datapath registers and held result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= {WIDTH{1'b0}};
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r  <= a_sh_r >> DIGIT;
                    b_sh_r  <= b_sh_r >> DIGIT;
                    psum_r  <= psum_next_s;
                    carry_r <= chain_c_s[DIGIT];
                    cnt_r   <= cnt_r + CW'(1);
                    busy    <= 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        s       <= psum_next_s;
                        cout    <= chain_c_s[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf     <= ovf_s;
`endif
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one bit-serial instance (DIGIT=1) and
// one nibble-serial instance (DIGIT=4), both WIDTH=8, sharing clock, reset and
// operand inputs but with separate start requests.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start1;
    logic       start4;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    logic       busy1, done1, cout1;
    logic [7:0] s1;
    logic       busy4, done4, cout4;
    logic [7:0] s4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf1, ovf4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] prev_s1 = 8'h00;
    logic [7:0] prev_s4 = 8'h00;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy4),
        .done  (done4),
        .s     (s4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input bit u4);
        return u4 ? done4 : done1;
    endfunction

    function automatic logic sel_busy(input bit u4);
        return u4 ? busy4 : busy1;
    endfunction

    function automatic logic [7:0] sel_s(input bit u4);
        return u4 ? s4 : s1;
    endfunction

    function automatic logic sel_cout(input bit u4);
        return u4 ? cout4 : cout1;
    endfunction

`ifdef SERIAL_ADDER_OVF_EN
    function automatic logic sel_ovf(input bit u4);
        return u4 ? ovf4 : ovf1;
    endfunction
`endif

    // One transaction on the chosen instance, checked against plain arithmetic.
    task automatic do_op(input bit u4, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input bit inject);
        logic [8:0] full;
        logic       exp_ovf;
        logic [7:0] held;
        int         n_exp;
        int         edges;
        logic       got;

        full    = {1'b0, av} + {1'b0, bv} + {8'h00, cv};
        exp_ovf = (av[7] == bv[7]) && (full[7] != av[7]);
        n_exp   = u4 ? 2 : 8;
        held    = u4 ? prev_s4 : prev_s1;

        @(negedge clk);
        a = av; b = bv; cin = cv;
        if (u4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        check("busy_after_accept", {31'b0, sel_busy(u4)}, 32'd1);
        // Operands are free to change once accepted.
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);

        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            if (inject && edges == 2) begin
                a = 8'hFF; b = 8'hFF;
                if (u4) start4 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0; start4 = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            got = sel_done(u4);
            if (!got && edges == 1) begin
                check("s_held_during_run", {24'b0, sel_s(u4)}, {24'b0, held});
            end
        end
        start1 = 1'b0; start4 = 1'b0;

        check("done_latency", edges, n_exp);
        check("sum", {24'b0, sel_s(u4)}, {24'b0, full[7:0]});
        check("cout", {31'b0, sel_cout(u4)}, {31'b0, full[8]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'b0, sel_ovf(u4)}, {31'b0, exp_ovf});
`endif
        check("busy_at_done", {31'b0, sel_busy(u4)}, 32'd1);

        @(posedge clk);
        #1;
        check("done_one_cycle", {31'b0, sel_done(u4)}, 32'd0);
        check("busy_released", {31'b0, sel_busy(u4)}, 32'd0);
        check("s_held_after", {24'b0, sel_s(u4)}, {24'b0, full[7:0]});

        if (u4) prev_s4 = full[7:0]; else prev_s1 = full[7:0];
    endtask

    initial begin
        logic idle_ok;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_s1", {24'b0, s1}, 32'd0);
        check("rst_cout1", {31'b0, cout1}, 32'd0);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_done1", {31'b0, done1}, 32'd0);
        check("rst_s4", {24'b0, s4}, 32'd0);
        check("rst_busy4", {31'b0, busy4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero operands, then the carry and pattern vectors.
        do_op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0);
        do_op(1'b0, 8'h0F, 8'hF0, 1'b0, 1'b0);

        // Nibble-serial instance.
        do_op(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
        do_op(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0);

        // A start during RUN must be ignored and not queued.
        do_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
        idle_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (busy1 !== 1'b0 || done1 !== 1'b0) idle_ok = 1'b0;
        end
        check("no_queued_request", {31'b0, idle_ok}, 32'd1);

        // Overflow vectors (ovf checked only when the feature is built).
        do_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);

        // Reset during the third RUN cycle aborts at once.
        @(negedge clk);
        a = 8'h55; b = 8'hAA; cin = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_s", {24'b0, s1}, 32'd0);
        check("abort_cout", {31'b0, cout1}, 32'd0);
        check("abort_done", {31'b0, done1}, 32'd0);
        check("abort_busy", {31'b0, busy1}, 32'd0);
        check("abort_s4", {24'b0, s4}, 32'd0);
        prev_s1 = 8'h00; prev_s4 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);

        // Randomised operands on both instances.
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            do_op(i[0], ra, rb, rc, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
